load_queue_n: RTL and testbench
===============================

LOAD_QUEUE_N -- requirements
Module: load_queue_n

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of load entries (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 6, destination physical-register tag width.
REQ-003 SHALL have parameter BM_W, default 4, branch-mask width.
REQ-004 SHALL have ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  new load offered.
- in_ready  out  1  at least one FREE entry.
- in_addr  in  32  byte address.
- in_size  in  2  0=byte, 1=half, 2=word.
- in_unsigned  in  1  zero-extend when 1.
- in_tag  in  TAG_W  destination tag.
- in_bmask  in  BM_W  branch dependencies.
- req_valid  out  1  cache/SQ request.
- req_ready  in  1  cache accepts request.
- req_addr  out  32  word-aligned address to cache and SQ.
- req_idx  out  log2(DEPTH)  issuing entry.
- fwd_data  in  32  SQ forwarded word, valid with req_valid.
- fwd_mask  in  4  per-byte forward valid.
- resp_valid  in  1  cache data return.
- resp_idx  in  log2(DEPTH)  returning entry.
- resp_data  in  32  returned word.
- cdb_req  out  DEPTH  entry DONE, requests CDB.
- cdb_gnt  in  DEPTH  one-hot or zero grant.
- cdb_valid  out  1  result broadcast.
- cdb_tag  out  TAG_W  result tag.
- cdb_data  out  32  extended result.
- b_resolve  in  BM_W  one-hot resolving branch, or zero.
- b_mispred  in  1  resolving branch mispredicted.

Function
REQ-005 Each entry SHALL hold state FREE, WAIT_ISSUE, WAIT_DATA, DONE or ORPHAN, plus addr, size, unsigned, tag, bmask, merged word, byte-valid mask.
REQ-006 in_ready SHALL be 1 iff any entry is FREE at cycle start; a FREE produced in the same cycle is not visible until the next cycle.
REQ-007 On in_valid&in_ready the lowest-index FREE entry SHALL become WAIT_ISSUE next cycle; byte-valid mask cleared.
REQ-008 req_valid SHALL be 1 iff any entry is WAIT_ISSUE; the selected entry is the lowest-index WAIT_ISSUE; req_addr={addr[31:2],2'b00}; outputs combinational from registered state.
REQ-009 On req_valid&req_ready the entry SHALL latch fwd_data bytes where fwd_mask=1; if fwd_mask=4'b1111 it SHALL go to DONE (no response expected), else WAIT_DATA.
REQ-010 If the cache does not accept, the request is re-presented, forward data re-sampled, no state change.
REQ-011 On resp_valid for a WAIT_DATA entry, bytes not forwarded SHALL take resp_data; forwarded bytes SHALL keep forwarded data; entry goes DONE.
REQ-012 Result SHALL select the byte/half at addr[1:0] (half uses addr[1]), sign- or zero-extend per in_unsigned; word returns merged word unchanged.
REQ-013 cdb_req[i] SHALL be 1 iff entry i is DONE; on cdb_gnt[i] with entry i DONE, cdb_valid=1, cdb_tag/cdb_data from entry i same cycle, entry goes FREE next cycle.
REQ-014 cdb_valid SHALL be 0 and cdb_tag/cdb_data 0 when no valid grant; grants to non-DONE entries SHALL be ignored.
REQ-015 Load latency with zero stall, no forward: accept cycle T, request T+1, response at T+1+L, cdb_req at T+2+L.
REQ-016 On b_resolve!=0 and b_mispred=1, every entry with bmask&b_resolve!=0 SHALL be squashed: WAIT_ISSUE/DONE -> FREE, WAIT_DATA -> ORPHAN; an incoming load with in_bmask&b_resolve!=0 SHALL not be allocated.
REQ-017 On b_resolve!=0 and b_mispred=0, the b_resolve bit SHALL be cleared in every entry's bmask and in the incoming in_bmask before storing.
REQ-018 ORPHAN entries SHALL not be allocatable, issue, or request CDB; resp_valid to an ORPHAN SHALL move it to FREE and discard data.
REQ-019 resp_valid to a FREE, WAIT_ISSUE or DONE entry SHALL be ignored.
REQ-020 Squash in the same cycle as response, issue or grant: squash wins; granted squashed entry SHALL not drive cdb_valid.
REQ-021 Issue and grant of different entries, allocation and free of different entries, SHALL all proceed in one cycle.

Reset
REQ-022 While reset is high at a rising edge, all entries SHALL become FREE and all stored fields 0, including ORPHAN entries; outstanding responses after reset are ignored.
REQ-023 After reset: in_ready=1, req_valid=0, cdb_req=0, cdb_valid=0, cdb_tag=0, cdb_data=0, req_addr=0, req_idx=0.

Verification
REQ-024 Byte load addr=0x1003 signed, resp_data=0x80FF_FF12, fwd_mask=0 -> cdb_data=0xFFFF_FF80, correct tag.
REQ-025 Word load, fwd_mask=4'b1111, fwd_data=0xDEAD_BEEF -> DONE without response, cdb_data=0xDEAD_BEEF; fwd_mask=4'b0011 with resp_data=0x1122_3344 -> 0x1122_BEEF.
REQ-026 Fill DEPTH loads, hold req_ready=0 -> in_ready=0, req_idx=0 held; grant one DONE entry -> in_ready=1 one cycle after free.
REQ-027 Entry in WAIT_DATA with bmask=4'b0010, b_resolve=4'b0010, b_mispred=1 -> ORPHAN, not reallocated; later response -> FREE, no cdb_valid.
REQ-028 Correct resolve b_resolve=4'b0001 on entries with bmask=4'b0011 -> bmask=4'b0010; subsequent mispredict on bit 0 squashes nothing.
REQ-029 Assert reset with loads in every state -> all outputs per REQ-023 next cycle; stale resp_valid ignored.

Source files
------------

// File: rtl/load_queue_n.sv
// load_queue_n: tracks in-flight loads from allocation through cache/store-queue
// issue, data return and CDB writeback, with branch-mask squash handling.
module load_queue_n #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int BM_W  = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [BM_W-1:0]  in_bmask,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [31:0]      req_addr,
    output logic [IDX_W-1:0] req_idx,
    input  logic [31:0]      fwd_data,
    input  logic [3:0]       fwd_mask,
    input  logic             resp_valid,
    input  logic [IDX_W-1:0] resp_idx,
    input  logic [31:0]      resp_data,
    output logic [DEPTH-1:0] cdb_req,
    input  logic [DEPTH-1:0] cdb_gnt,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    input  logic [BM_W-1:0]  b_resolve,
    input  logic             b_mispred
);

    logic [DEPTH-1:0]             ent_free;
    logic [DEPTH-1:0]             ent_wait_issue;
    logic [DEPTH-1:0]             ent_done;
    logic [DEPTH-1:0]             ent_gnt_ok;
    logic [DEPTH-1:0]             alloc_oh;
    logic [DEPTH-1:0]             issue_oh;
    logic [DEPTH-1:0][31:0]       ent_addr;
    logic [DEPTH-1:0][31:0]       ent_result;
    logic [DEPTH-1:0][TAG_W-1:0]  ent_tag;
    logic                         in_squash;
    logic [BM_W-1:0]              in_bmask_st;

    // Incoming load killed by a same-cycle mispredict, or its resolved bit dropped.
    assign in_squash   = b_mispred && |(in_bmask & b_resolve);
    assign in_bmask_st = b_mispred ? in_bmask : (in_bmask & ~b_resolve);
    assign in_ready    = |ent_free;
    assign req_valid   = |ent_wait_issue;
    assign cdb_req     = ent_done;
    assign cdb_valid   = |ent_gnt_ok;

    // Allocate into the lowest-index FREE entry.
    always_comb begin
        logic found;
        found    = 1'b0;
        alloc_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_free[i] && !found) begin
                found       = 1'b1;
                alloc_oh[i] = in_valid && !in_squash;
            end
        end
    end

    // Present the lowest-index WAIT_ISSUE entry to the cache and store queue.
    always_comb begin
        logic found;
        found    = 1'b0;
        req_idx  = '0;
        req_addr = '0;
        issue_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_wait_issue[i] && !found) begin
                found       = 1'b1;
                req_idx     = IDX_W'(i);
                req_addr    = ent_addr[i];
                issue_oh[i] = req_ready;
            end
        end
    end

    // Broadcast the granted entry; grants are one-hot so OR-muxing is safe.
    always_comb begin
        cdb_tag  = '0;
        cdb_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_gnt_ok[i]) begin
                cdb_tag  = cdb_tag | ent_tag[i];
                cdb_data = cdb_data | ent_result[i];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        load_queue_entry #(
            .TAG_W(TAG_W),
            .BM_W (BM_W)
        ) u_ent (
            .clock        (clock),
            .reset        (reset),
            .alloc        (alloc_oh[i]),
            .in_addr      (in_addr),
            .in_size      (in_size),
            .in_unsigned  (in_unsigned),
            .in_tag       (in_tag),
            .in_bmask     (in_bmask_st),
            .issue        (issue_oh[i]),
            .fwd_data     (fwd_data),
            .fwd_mask     (fwd_mask),
            .resp         (resp_valid && (resp_idx == IDX_W'(i))),
            .resp_data    (resp_data),
            .grant        (cdb_gnt[i]),
            .b_resolve    (b_resolve),
            .b_mispred    (b_mispred),
            .is_free      (ent_free[i]),
            .is_wait_issue(ent_wait_issue[i]),
            .is_done      (ent_done[i]),
            .gnt_ok       (ent_gnt_ok[i]),
            .req_addr     (ent_addr[i]),
            .tag          (ent_tag[i]),
            .result       (ent_result[i])
        );
    end

endmodule

// load_queue_entry: one load slot; owns its state machine, merged data and
// the byte/half/word extraction of its result.
module load_queue_entry #(
    parameter int TAG_W = 6,
    parameter int BM_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc,
    input  logic [31:0]      in_addr,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [BM_W-1:0]  in_bmask,
    input  logic             issue,
    input  logic [31:0]      fwd_data,
    input  logic [3:0]       fwd_mask,
    input  logic             resp,
    input  logic [31:0]      resp_data,
    input  logic             grant,
    input  logic [BM_W-1:0]  b_resolve,
    input  logic             b_mispred,
    output logic             is_free,
    output logic             is_wait_issue,
    output logic             is_done,
    output logic             gnt_ok,
    output logic [31:0]      req_addr,
    output logic [TAG_W-1:0] tag,
    output logic [31:0]      result
);

    typedef enum logic [2:0] {
        S_FREE, S_WAIT_ISSUE, S_WAIT_DATA, S_DONE, S_ORPHAN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [BM_W-1:0]  bmask_q, bmask_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       bval_q, bval_d;
    logic             squash;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    assign squash        = b_mispred && |(bmask_q & b_resolve);
    assign is_free       = (state_q == S_FREE);
    assign is_wait_issue = (state_q == S_WAIT_ISSUE);
    assign is_done       = (state_q == S_DONE);
    assign gnt_ok        = grant && is_done && !squash;
    assign req_addr      = {addr_q[31:2], 2'b00};
    assign tag           = tag_q;

    // Next-state: lifecycle transitions, then a squash overrides whatever else happened.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        tag_d   = tag_q;
        bmask_d = bmask_q;
        data_d  = data_q;
        bval_d  = bval_q;
        if (!b_mispred) bmask_d = bmask_q & ~b_resolve;
        case (state_q)
            S_FREE: begin
                if (alloc) begin
                    state_d = S_WAIT_ISSUE;
                    addr_d  = in_addr;
                    size_d  = in_size;
                    uns_d   = in_unsigned;
                    tag_d   = in_tag;
                    bmask_d = in_bmask;
                    data_d  = '0;
                    bval_d  = '0;
                end
            end
            S_WAIT_ISSUE: begin
                if (issue) begin
                    for (int k = 0; k < 4; k++)
                        if (fwd_mask[k]) data_d[8*k +: 8] = fwd_data[8*k +: 8];
                    bval_d  = fwd_mask;
                    state_d = (fwd_mask == 4'hF) ? S_DONE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (resp) begin
                    // Forwarded bytes are younger than the cache copy and must survive.
                    for (int k = 0; k < 4; k++)
                        if (!bval_q[k]) data_d[8*k +: 8] = resp_data[8*k +: 8];
                    bval_d  = 4'hF;
                    state_d = S_DONE;
                end
            end
            S_DONE:   if (grant) state_d = S_FREE;
            S_ORPHAN: if (resp)  state_d = S_FREE;
            default:  state_d = S_FREE;
        endcase
        if (squash) begin
            case (state_q)
                S_WAIT_ISSUE, S_DONE: state_d = S_FREE;
                S_WAIT_DATA:          state_d = S_ORPHAN;
                default:              ;
            endcase
        end
    end

    // Extract and extend the addressed byte/half from the merged word.
    always_comb begin
        byte_sel = data_q[7:0];
        case (addr_q[1:0])
            2'd1:    byte_sel = data_q[15:8];
            2'd2:    byte_sel = data_q[23:16];
            2'd3:    byte_sel = data_q[31:24];
            default: byte_sel = data_q[7:0];
        endcase
        half_sel = addr_q[1] ? data_q[31:16] : data_q[15:0];
        case (size_q)
            2'd0:    result = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'd1:    result = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result = data_q;
        endcase
    end

    // Entry registers; reset clears every field, orphans included.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FREE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            tag_q   <= '0;
            bmask_q <= '0;
            data_q  <= '0;
            bval_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            tag_q   <= tag_d;
            bmask_q <= bmask_d;
            data_q  <= data_d;
            bval_q  <= bval_d;
        end
    end

endmodule

// File: tb/tb_load_queue_n.sv
// Directed bench for load_queue_n: stimulus pushes expected CDB results into a
// scoreboard queue, an independent monitor pops and compares on cdb_valid.
module tb_load_queue_n;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic [5:0]  in_tag = '0;
    logic [3:0]  in_bmask = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic [1:0]  req_idx;
    logic [31:0] fwd_data = '0;
    logic [3:0]  fwd_mask = '0;
    logic        resp_valid = 1'b0;
    logic [1:0]  resp_idx = '0;
    logic [31:0] resp_data = '0;
    logic [3:0]  cdb_req;
    logic [3:0]  cdb_gnt = '0;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [3:0]  b_resolve = '0;
    logic        b_mispred = 1'b0;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    load_queue_n #(.DEPTH(4), .TAG_W(6), .BM_W(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_tag(in_tag), .in_bmask(in_bmask),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_idx(req_idx),
        .fwd_data(fwd_data), .fwd_mask(fwd_mask),
        .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_data(resp_data),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .b_resolve(b_resolve), .b_mispred(b_mispred)
    );

    always #5 clock = ~clock;

    // Monitor: every broadcast must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (cdb_valid) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cdb_unexpected got tag=%0d data=%h", cdb_tag, cdb_data);
            end else begin
                e = exp_q.pop_front();
                if (cdb_tag !== e.tag || cdb_data !== e.data) begin
                    bad++;
                    $display("FAIL cdb_result got tag=%0d data=%h want tag=%0d data=%h",
                             cdb_tag, cdb_data, e.tag, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [5:0] t, input logic [31:0] d);
        exp_t e;
        e.tag  = t;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic u,
                        input logic [5:0] t, input logic [3:0] bm);
        in_valid = 1'b1; in_addr = a; in_size = s; in_unsigned = u; in_tag = t; in_bmask = bm;
        step();
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] m, input logic [31:0] d);
        req_ready = 1'b1; fwd_mask = m; fwd_data = d;
        step();
        req_ready = 1'b0; fwd_mask = '0; fwd_data = '0;
    endtask

    task automatic respond(input logic [1:0] idx, input logic [31:0] d);
        resp_valid = 1'b1; resp_idx = idx; resp_data = d;
        step();
        resp_valid = 1'b0;
    endtask

    task automatic grant(input logic [1:0] idx);
        cdb_gnt = 4'b0001 << idx;
        step();
        cdb_gnt = '0;
    endtask

    task automatic mispredict(input logic [3:0] br);
        b_resolve = br; b_mispred = 1'b1;
        step();
        b_resolve = '0; b_mispred = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tagname);
        check({tagname, "_in_ready"}, in_ready, 1);
        check({tagname, "_req_valid"}, req_valid, 0);
        check({tagname, "_cdb_req"}, cdb_req, 0);
        check({tagname, "_cdb_valid"}, cdb_valid, 0);
        check({tagname, "_cdb_tag"}, cdb_tag, 0);
        check({tagname, "_cdb_data"}, cdb_data, 0);
        check({tagname, "_req_addr"}, req_addr, 0);
        check({tagname, "_req_idx"}, req_idx, 0);
    endtask

    // One load end-to-end through entry 0 with an empty queue.
    task automatic run_simple(input logic [31:0] a, input logic [1:0] s, input logic u,
                              input logic [5:0] t, input logic [3:0] m, input logic [31:0] fd,
                              input logic [31:0] rd, input logic [31:0] want);
        load(a, s, u, t, 4'b0000);
        check("simple_req_idx", req_idx, 0);
        check("simple_req_addr", req_addr, {a[31:2], 2'b00});
        issue(m, fd);
        if (m != 4'hF) respond(2'd0, rd);
        check("simple_cdb_req", cdb_req, 4'b0001);
        push(t, want);
        grant(2'd0);
        check("simple_freed", cdb_req, 0);
    endtask

    initial begin
        step(); step();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Extraction / merge patterns
        run_simple(32'h1003, 2'd0, 1'b0, 6'd5,  4'h0, 32'h0,         32'h80FF_FF12, 32'hFFFF_FF80);
        run_simple(32'h2000, 2'd2, 1'b0, 6'd7,  4'hF, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF);
        run_simple(32'h2004, 2'd2, 1'b0, 6'd8,  4'h3, 32'hDEAD_BEEF, 32'h1122_3344, 32'h1122_BEEF);
        run_simple(32'h3002, 2'd1, 1'b1, 6'd9,  4'h0, 32'h0,         32'h8001_7FFF, 32'h0000_8001);
        run_simple(32'h3000, 2'd1, 1'b0, 6'd10, 4'h0, 32'h0,         32'h1234_F00D, 32'hFFFF_F00D);
        run_simple(32'h3001, 2'd0, 1'b1, 6'd11, 4'h2, 32'h0000_9A00, 32'h1234_5678, 32'h0000_009A);
        run_simple(32'h3006, 2'd0, 1'b0, 6'd12, 4'h0, 32'h0,         32'h007F_0000, 32'h0000_007F);

        // Fill, stall, free one, concurrent issue/grant/alloc
        load(32'h4000, 2'd2, 1'b0, 6'd20, 4'h0);
        load(32'h4004, 2'd2, 1'b0, 6'd21, 4'h0);
        load(32'h4008, 2'd2, 1'b0, 6'd22, 4'h0);
        load(32'h400C, 2'd2, 1'b0, 6'd23, 4'h0);
        check("full_in_ready", in_ready, 0);
        check("full_req_valid", req_valid, 1);
        check("full_req_idx", req_idx, 0);
        load(32'h4FFC, 2'd2, 1'b0, 6'd63, 4'h0);
        check("full_hold_req_idx", req_idx, 0);
        check("full_hold_req_addr", req_addr, 32'h4000);
        issue(4'hF, 32'hA0A0_A0A0);
        push(6'd20, 32'hA0A0_A0A0);
        check("full_done_req", cdb_req, 4'b0001);
        check("full_next_idx", req_idx, 1);
        cdb_gnt = 4'b0001;
        #1;
        check("full_ready_same_cycle", in_ready, 0);
        step();
        cdb_gnt = '0;
        check("full_ready_after_free", in_ready, 1);
        req_ready = 1'b1; fwd_mask = 4'hF; fwd_data = 32'h1111_1111;
        push(6'd21, 32'h1111_1111);
        step();
        fwd_data = 32'h2222_2222;
        push(6'd22, 32'h2222_2222);
        cdb_gnt = 4'b0010;
        in_valid = 1'b1; in_addr = 32'h5000; in_size = 2'd2; in_unsigned = 1'b0;
        in_tag = 6'd24; in_bmask = 4'h0;
        step();
        in_valid = 1'b0;
        check("concurrent_alloc_idx", req_idx, 0);
        fwd_data = 32'h3333_3333;
        push(6'd24, 32'h3333_3333);
        cdb_gnt = 4'b0100;
        step();
        fwd_data = 32'h4444_4444;
        push(6'd23, 32'h4444_4444);
        cdb_gnt = 4'b0001;
        step();
        req_ready = 1'b0; fwd_mask = '0; fwd_data = '0;
        cdb_gnt = 4'b1000;
        step();
        cdb_gnt = '0;
        check("drain_cdb_req", cdb_req, 0);
        check("drain_req_valid", req_valid, 0);
        check("drain_in_ready", in_ready, 1);

        // Mispredict orphans a WAIT_DATA entry and blocks a dependent incoming load
        load(32'h6000, 2'd2, 1'b0, 6'd30, 4'b0010);
        issue(4'h0, 32'h0);
        in_valid = 1'b1; in_addr = 32'h6100; in_size = 2'd2; in_tag = 6'd31; in_bmask = 4'b0010;
        mispredict(4'b0010);
        in_valid = 1'b0;
        check("orphan_no_alloc", req_valid, 0);
        check("orphan_no_cdb", cdb_req, 0);
        load(32'h6200, 2'd2, 1'b0, 6'd32, 4'h0);
        check("orphan_skip_idx", req_idx, 1);
        issue(4'hF, 32'h3232_3232);
        push(6'd32, 32'h3232_3232);
        respond(2'd0, 32'h9999_9999);
        check("orphan_resp_silent", cdb_req, 4'b0010);
        grant(2'd1);
        load(32'h6300, 2'd2, 1'b0, 6'd33, 4'h0);
        check("orphan_reuse_idx", req_idx, 0);
        issue(4'hF, 32'h3333_0000);
        push(6'd33, 32'h3333_0000);
        grant(2'd0);

        // Correct resolve clears mask bits, including on the incoming load
        load(32'h7000, 2'd2, 1'b0, 6'd40, 4'b0011);
        load(32'h7004, 2'd2, 1'b0, 6'd41, 4'b0011);
        b_resolve = 4'b0001; b_mispred = 1'b0;
        load(32'h7008, 2'd2, 1'b0, 6'd42, 4'b0001);
        b_resolve = '0;
        mispredict(4'b0001);
        check("resolve_no_squash_idx", req_idx, 0);
        check("resolve_no_squash_ready", in_ready, 1);
        mispredict(4'b0010);
        check("resolve_partial_squash_idx", req_idx, 2);
        issue(4'hF, 32'h4242_4242);
        push(6'd42, 32'h4242_4242);
        check("resolve_cdb_req", cdb_req, 4'b0100);
        grant(2'd2);
        check("resolve_empty", req_valid, 0);

        // Squash beats grant and response in the same cycle
        load(32'h7100, 2'd2, 1'b0, 6'd50, 4'b1000);
        issue(4'hF, 32'h5050_5050);
        cdb_gnt = 4'b0001; b_resolve = 4'b1000; b_mispred = 1'b1;
        #1;
        check("squash_grant_valid", cdb_valid, 0);
        check("squash_grant_data", cdb_data, 0);
        step();
        cdb_gnt = '0; b_resolve = '0; b_mispred = 1'b0;
        check("squash_grant_freed", cdb_req, 0);
        load(32'h7200, 2'd2, 1'b0, 6'd51, 4'b1000);
        issue(4'h0, 32'h0);
        resp_valid = 1'b1; resp_idx = 2'd0; resp_data = 32'h5151_5151;
        mispredict(4'b1000);
        resp_valid = 1'b0;
        check("squash_resp_no_done", cdb_req, 0);
        load(32'h7300, 2'd2, 1'b0, 6'd52, 4'h0);
        check("squash_resp_orphan_idx", req_idx, 1);
        respond(2'd0, 32'h0);
        issue(4'hF, 32'h5252_5252);
        push(6'd52, 32'h5252_5252);
        grant(2'd1);

        // Reset with entries in every state
        load(32'h8000, 2'd2, 1'b0, 6'd60, 4'h0);
        issue(4'h0, 32'h0);
        load(32'h8004, 2'd2, 1'b0, 6'd61, 4'b0100);
        issue(4'h0, 32'h0);
        mispredict(4'b0100);
        load(32'h8008, 2'd2, 1'b0, 6'd62, 4'h0);
        issue(4'hF, 32'h6262_6262);
        load(32'h800C, 2'd2, 1'b0, 6'd63, 4'h0);
        check("pre_reset_in_ready", in_ready, 0);
        check("pre_reset_cdb_req", cdb_req, 4'b0100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        respond(2'd0, 32'h1234_5678);
        respond(2'd1, 32'h8765_4321);
        check("stale_resp_cdb_req", cdb_req, 0);
        check("stale_resp_in_ready", in_ready, 1);
        run_simple(32'h9000, 2'd2, 1'b0, 6'd13, 4'h0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);

        step(); step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
